// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and fills the IF/ID register.
// Optional performance counters are enabled by defining FETCH_PERF_COUNT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 2048,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_target_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    output logic        if_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_pc_plus4_o,
    output logic        fault_o,
`ifdef FETCH_PERF_COUNT_EN
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_stall_o,
`endif
    output logic [31:0] fault_pc_o
);

    localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    state_t      r_state, w_state_n;
    logic [31:0] r_pc, w_pc_n;
    logic        r_valid, w_valid_n;
    logic [31:0] r_instr, w_instr_n;
    logic [31:0] r_if_pc, w_if_pc_n;
    logic [31:0] r_if_pc4, w_if_pc4_n;
    logic        r_fault, w_fault_n;
    logic [31:0] r_fault_pc, w_fault_pc_n;
    logic        w_legal;
    logic [31:0] w_pc_plus4;

    // Range check uses the upper bound directly so pc+4 wrap can never look legal.
    assign w_legal    = (r_pc[1:0] == 2'b00) && (r_pc <= LAST_PC);
    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_valid    <= 1'b0;
            r_instr    <= NOP_INSTR;
            r_if_pc    <= '0;
            r_if_pc4   <= '0;
            r_fault    <= 1'b0;
            r_fault_pc <= '0;
        end else begin
            r_state    <= w_state_n;
            r_pc       <= w_pc_n;
            r_valid    <= w_valid_n;
            r_instr    <= w_instr_n;
            r_if_pc    <= w_if_pc_n;
            r_if_pc4   <= w_if_pc4_n;
            r_fault    <= w_fault_n;
            r_fault_pc <= w_fault_pc_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_pc_n       = r_pc;
        w_valid_n    = r_valid;
        w_instr_n    = r_instr;
        w_if_pc_n    = r_if_pc;
        w_if_pc4_n   = r_if_pc4;
        w_fault_n    = r_fault;
        w_fault_pc_n = r_fault_pc;
        if (r_state == ST_RUN) begin
            if (redirect_i) begin
                w_pc_n     = redirect_target_i;
                w_valid_n  = 1'b0;
                w_instr_n  = NOP_INSTR;
                w_if_pc_n  = '0;
                w_if_pc4_n = '0;
            end else if (!stall_i) begin
                if (w_legal) begin
                    w_pc_n     = w_pc_plus4;
                    w_valid_n  = 1'b1;
                    w_instr_n  = imem_instr_i;
                    w_if_pc_n  = r_pc;
                    w_if_pc4_n = w_pc_plus4;
                end else begin
                    w_state_n    = ST_HALT;
                    w_valid_n    = 1'b0;
                    w_instr_n    = NOP_INSTR;
                    w_if_pc_n    = '0;
                    w_if_pc4_n   = '0;
                    w_fault_n    = 1'b1;
                    w_fault_pc_n = r_pc;
                end
            end
        end
    end

`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;
    logic        w_fetch_hit;
    logic        w_stall_hit;

    assign w_fetch_hit = (r_state == ST_RUN) && !redirect_i && !stall_i && w_legal;
    assign w_stall_hit = (r_state == ST_RUN) && !redirect_i && stall_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_fetch_hit) r_perf_fetch <= r_perf_fetch + 32'd1;
            if (w_stall_hit) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetch_o = r_perf_fetch;
    assign perf_stall_o = r_perf_stall;
`endif

    assign imem_addr_o   = r_pc;
    assign if_valid_o    = r_valid;
    assign if_instr_o    = r_instr;
    assign if_pc_o       = r_if_pc;
    assign if_pc_plus4_o = r_if_pc4;
    assign fault_o       = r_fault;
    assign fault_pc_o    = r_fault_pc;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the DPTR datapath: owns the program counter, drives the byte address into the combinational instruction memory and captures the returned word into the IF/ID pipeline register.
- Handles sequential PC+4 advance, branch/jump redirect from EX, stall from hazard logic, and halts on misaligned or out-of-range fetch addresses.
- Sits directly upstream of the instruction memory and directly feeds the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_BYTES, 2048, instruction memory size in bytes; a fetch is legal only if pc+3 < MEM_BYTES.
- NOP_INSTR, 32'h0000_0013, word placed in IF/ID on bubbles and faults.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- stall_i  input  1  hold PC and IF/ID contents.
- redirect_i  input  1  branch taken or jump; load redirect_target_i into PC.
- redirect_target_i  input  32  new PC on redirect.
- imem_addr_o  output  32  byte address to instruction memory (= pc_q, combinational).
- imem_instr_i  input  32  instruction word returned combinationally by memory.
- if_valid_o  output  1  IF/ID register holds a real instruction.
- if_instr_o  output  32  IF/ID instruction.
- if_pc_o  output  32  IF/ID PC of that instruction.
- if_pc_plus4_o  output  32  IF/ID pc+4 (link value).
- fault_o  output  1  sticky fetch fault.
- fault_pc_o  output  32  PC that caused the fault.

Behaviour:
- Reset (rst_i=1 at clock edge): pc_q=RESET_PC, state=RUN, if_valid_o=0, if_instr_o=NOP_INSTR, if_pc_o=0, if_pc_plus4_o=0, fault_o=0, fault_pc_o=0. Reset overrides all other inputs, including mid-stall or mid-redirect.
- imem_addr_o = pc_q at all times; no added latency. Instruction for pc_q appears in IF/ID one cycle after pc_q is presented.
- Legal fetch: pc_q[1:0]==0 and pc_q <= MEM_BYTES-4, evaluated combinationally on pc_q.
- State RUN, priority per edge: redirect_i > stall_i > normal.
  - redirect_i=1: pc_q<=redirect_target_i; IF/ID loads bubble (valid=0, instr=NOP_INSTR, pc fields=0). Applies even when stall_i=1.
  - stall_i=1, redirect_i=0: pc_q and all IF/ID fields hold.
  - Normal, legal fetch: IF/ID <= {valid=1, imem_instr_i, pc_q, pc_q+4}; pc_q<=pc_q+4.
  - Normal, illegal fetch: IF/ID loads bubble; fault_o<=1; fault_pc_o<=pc_q; state<=HALT.
- State HALT: pc_q, IF/ID bubble and fault outputs hold; stall_i and redirect_i ignored. Only rst_i leaves HALT.
- The illegal-fetch check applies only in the normal case; a misaligned redirect_target_i is accepted into pc_q and faults on the next non-stalled cycle.
- pc_q+4 uses modulo-2^32 arithmetic; wrap to 0 is not special-cased and is caught by the range check first.

Optional Feature:
- Macro FETCH_PERF_COUNT_EN.
- Defined: adds outputs perf_fetch_o[31:0] (count of IF/ID loads with valid=1) and perf_stall_o[31:0] (cycles in RUN with stall_i=1 and redirect_i=0). Both reset to 0 and wrap modulo 2^32.
- Not defined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then 3 free cycles with mem words 0x11111111, 0x22222222, 0x33333333 at 0, 4, 8 -> IF/ID shows pc 0, 4, 8 in turn, with pc_plus4 4, 8, 12 and valid=1.
- stall_i high 2 cycles at pc_q=8 -> imem_addr_o stays 8 and IF/ID holds pc=4 / 0x22222222. On release, the next IF/ID entry is pc=8.
- redirect_i=1 with target 0x100 while stall_i=1 -> next cycle pc_q=0x100 and IF/ID valid=0, instr=0x00000013. The following cycle IF/ID pc=0x100.
- Redirect to 0x102 -> one bubble, then fault_o=1, fault_pc_o=0x102, valid=0. Further redirects are ignored until rst_i.
- Sequential run to pc_q=0x7FC then 0x800 -> 0x7FC is fetched valid; 0x800 faults with fault_pc_o=0x800.
- rst_i asserted during HALT and during a stall -> all outputs return to reset values next cycle and pc_q=RESET_PC. With FETCH_PERF_COUNT_EN defined, the counters read 0.
